// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blank/de and line/frame strobes.
// Define VIDEO_TIMING_GEN_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module video_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_sync,
    output logic             v_sync,
    output logic             blank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             blank_q, blank_d;
    logic             h_zero_q, h_zero_d;
    logic             f_zero_q, f_zero_d;
    logic             frame_wrap;

    // Decodes are taken from the next counter values so every registered
    // output lines up with the counters it describes.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        frame_wrap = 1'b0;
        if (en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d    = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_cnt_d = v_cnt_q + CNT_W'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
        h_sync_d = ((h_cnt_d >= H_SS) && (h_cnt_d < H_SE)) ? HS_POL : ~HS_POL;
        v_sync_d = ((v_cnt_d >= V_SS) && (v_cnt_d < V_SE)) ? VS_POL : ~VS_POL;
        blank_d  = (h_cnt_d >= H_VIS) || (v_cnt_d >= V_VIS);
        h_zero_d = (h_cnt_d == '0);
        f_zero_d = (h_cnt_d == '0) && (v_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q  <= '0;
            v_cnt_q  <= '0;
            h_sync_q <= ~HS_POL;
            v_sync_q <= ~VS_POL;
            blank_q  <= 1'b0;
            h_zero_q <= 1'b1;
            f_zero_q <= 1'b1;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            h_sync_q <= h_sync_d;
            v_sync_q <= v_sync_d;
            blank_q  <= blank_d;
            h_zero_q <= h_zero_d;
            f_zero_q <= f_zero_d;
        end
    end

`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    logic unused_wrap;
    assign unused_wrap = frame_wrap;
`endif

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign h_sync = h_sync_q;
    assign v_sync = v_sync_q;
    assign blank  = blank_q;
    assign de     = ~blank_q;

    // Strobes mark the pixel actually consumed, so they are gated by the live enable.
    assign line_start  = h_zero_q & en;
    assign frame_start = f_zero_q & en;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: default timing and a small positive-polarity mode.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    logic [10:0] h_a, v_a;
    logic        hs_a, vs_a, bl_a, de_a, ls_a, fs_a;
    logic [3:0]  h_b, v_b;
    logic        hs_b, vs_b, bl_b, de_b, ls_b, fs_b;
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    video_timing_gen dut_a (
        .clk(clk), .rst(rst), .en(en),
        .h_cnt(h_a), .v_cnt(v_a), .h_sync(hs_a), .v_sync(vs_a),
        .blank(bl_a), .de(de_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    video_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .h_cnt(h_b), .v_cnt(v_b), .h_sync(hs_b), .v_sync(vs_b),
        .blank(bl_b), .de(de_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    typedef struct {
        int h, v;
        bit hs, vs, bl, ls, fs;
        int fc;
    } exp_t;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t cfg_b = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1};

    exp_t q_a[$];
    exp_t q_b[$];

    int n_vec = 0;
    int n_err = 0;

    // Model state: linear pixel index within the frame plus completed-frame count.
    int p_a = 0, p_b = 0;
    int f_a = 0, f_b = 0;

    function automatic int tot(input cfg_t c);
        return (c.hv + c.hf + c.hs + c.hb) * (c.vv + c.vf + c.vs + c.vb);
    endfunction

    function automatic exp_t predict(input cfg_t c, input int p, input bit e, input int fc);
        exp_t r;
        int   ht;
        ht   = c.hv + c.hf + c.hs + c.hb;
        r.h  = p % ht;
        r.v  = p / ht;
        r.hs = (r.h >= c.hv + c.hf && r.h < c.hv + c.hf + c.hs) ? c.hp : !c.hp;
        r.vs = (r.v >= c.vv + c.vf && r.v < c.vv + c.vf + c.vs) ? c.vp : !c.vp;
        r.bl = (r.h >= c.hv) || (r.v >= c.vv);
        r.ls = e && (r.h == 0);
        r.fs = e && (p == 0);
        r.fc = fc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: present inputs, queue expectations, advance the model at the edge.
    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        q_a.push_back(predict(cfg_a, p_a, e, f_a));
        q_b.push_back(predict(cfg_b, p_b, e, f_b));
        @(posedge clk);
        #1;
        if (r) begin
            p_a = 0; p_b = 0; f_a = 0; f_b = 0;
        end else if (e) begin
            p_a = (p_a + 1) % tot(cfg_a);
            if (p_a == 0) f_a = (f_a + 1) % 65536;
            p_b = (p_b + 1) % tot(cfg_b);
            if (p_b == 0) f_b = (f_b + 1) % 65536;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_h_cnt", 32'(h_a), e.h);
            chk("a_v_cnt", 32'(v_a), e.v);
            chk("a_h_sync", 32'(hs_a), 32'(e.hs));
            chk("a_v_sync", 32'(vs_a), 32'(e.vs));
            chk("a_blank", 32'(bl_a), 32'(e.bl));
            chk("a_de", 32'(de_a), 32'(!e.bl));
            chk("a_line_start", 32'(ls_a), 32'(e.ls));
            chk("a_frame_start", 32'(fs_a), 32'(e.fs));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
            chk("a_frame_cnt", 32'(fc_a), e.fc);
`endif
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_h_cnt", 32'(h_b), e.h);
            chk("b_v_cnt", 32'(v_b), e.v);
            chk("b_h_sync", 32'(hs_b), 32'(e.hs));
            chk("b_v_sync", 32'(vs_b), 32'(e.vs));
            chk("b_blank", 32'(bl_b), 32'(e.bl));
            chk("b_de", 32'(de_b), 32'(!e.bl));
            chk("b_line_start", 32'(ls_b), 32'(e.ls));
            chk("b_frame_start", 32'(fs_b), 32'(e.fs));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
            chk("b_frame_cnt", 32'(fc_b), e.fc);
`endif
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));
        // Continuous enable: first lines of the default frame, many small frames.
        for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);
        // Alternating enable.
        for (int i = 0; i < 1700; i++) step(1'b0, 1'(i % 2 == 0));
        // Random enable.
        for (int i = 0; i < 3000; i++) step(1'b0, 1'($urandom_range(0, 1)));
        // Mid-line resets followed by idle cycles, then restart.
        for (int k = 0; k < 4; k++) begin
            int run;
            run = $urandom_range(50, 900);
            for (int i = 0; i < run; i++) step(1'b0, 1'b1);
            step(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step(1'b0, 1'b0);
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        end
        // Random enable with occasional reset.
        for (int i = 0; i < 5000; i++) step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));
        step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
